requant_channel_sequencer: RTL and testbench

- Sequences the requantizer engine across the output channels of one layer.
- Per channel: fetches M0/right_shift/bias from a per-channel parameter table, drives channel_idx and the parameters, holds start, waits for end_flag, then advances.
- Sits between the engine's register file (configuration, status) and the requantizer core.
- Replaces manual per-channel start/poll by software; reports done, abort, timeout and an interrupt pulse.

---
 rtl/requant_seq_pkg.sv | 26 ++
 rtl/requant_seq_watchdog.sv | 30 +++
 rtl/requant_channel_sequencer.sv | 177 +++++++++++++++++
 tb/tb_requant_channel_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/requant_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | requant_seq_pkg : state encoding and default widths for the      |
// |                   requantizer channel sequencer.   Rev 1.0       |
// +------------------------------------------------------------------+
package requant_seq_pkg;

  localparam int c_BW_DATA    = 32;
  localparam int c_BW_CH      = 16;
  localparam int c_PTAB_DEPTH = 256;
  localparam int c_BW_PINDEX  = 8;
  localparam int c_BW_TIMEOUT = 32;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t c_IDLE   = 3'd0;
  localparam seq_state_t c_FETCH  = 3'd1;
  localparam seq_state_t c_LATCH  = 3'd2;
  localparam seq_state_t c_LAUNCH = 3'd3;
  localparam seq_state_t c_WAIT   = 3'd4;
  localparam seq_state_t c_DRAIN  = 3'd5;
  localparam seq_state_t c_NEXT   = 3'd6;
  localparam seq_state_t c_DONE   = 3'd7;

endpackage
`default_nettype wire

// File: rtl/requant_seq_watchdog.sv
`default_nettype none
// +------------------------------------------------------------------+
// | requant_seq_watchdog : clearable cycle counter that flags the    |
// |                        last allowed cycle of a bounded wait.     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module requant_seq_watchdog #(
  parameter int BW_TIMEOUT = 32
) (
  input  logic                  clk,
  input  logic                  rstnn,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [BW_TIMEOUT-1:0] limit,
  output logic                  expire
);

  logic [BW_TIMEOUT-1:0] r_count;

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn)      r_count <= '0;
    else if (clear)  r_count <= '0;
    else if (enable) r_count <= r_count + 1'b1;
  end

  // A zero limit disables expiry entirely.
  assign expire = enable && (limit != '0) && (r_count == limit - 1'b1);

endmodule
`default_nettype wire

// File: rtl/requant_channel_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | requant_channel_sequencer : walks the requantizer engine across  |
// |                             all output channels of a layer.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module requant_channel_sequencer
  import requant_seq_pkg::*;
#(
  parameter int BW_DATA    = c_BW_DATA,
  parameter int BW_CH      = c_BW_CH,
  parameter int PTAB_DEPTH = c_PTAB_DEPTH,
  parameter int BW_PINDEX  = c_BW_PINDEX,
  parameter int BW_TIMEOUT = c_BW_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rstnn,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [BW_CH-1:0]      cfg_num_channel,
  input  logic [BW_TIMEOUT-1:0] cfg_timeout,
  output logic                  ptab_renable,
  output logic [BW_PINDEX-1:0]  ptab_rindex,
  input  logic [BW_DATA-1:0]    ptab_rdata_m0,
  input  logic [BW_DATA-1:0]    ptab_rdata_shift,
  input  logic [BW_DATA-1:0]    ptab_rdata_bias,
  output logic                  eng_start,
  output logic [BW_CH-1:0]      eng_channel_idx,
  output logic [BW_DATA-1:0]    eng_m0,
  output logic [BW_DATA-1:0]    eng_shift,
  output logic [BW_DATA-1:0]    eng_bias,
  input  logic                  eng_end_flag,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  err_cfg,
  output logic                  irq,
  output logic [BW_CH-1:0]      cur_channel
);

  // One extra bit so a table as deep as the channel range still compares correctly.
  localparam logic [BW_CH:0] c_PTAB_LIMIT = (BW_CH+1)'(PTAB_DEPTH);

  seq_state_t            r_state;
  logic [BW_CH-1:0]      r_channel;
  logic [BW_CH-1:0]      r_num_ch;
  logic [BW_TIMEOUT-1:0] r_timeout;

  logic             w_wd_clear;
  logic             w_wd_en;
  logic             w_wd_expire;
  logic             w_abort;
  logic             w_cfg_err;
  logic [BW_CH-1:0] w_ch_next;

  assign w_wd_clear  = (r_state == c_LAUNCH);
  assign w_wd_en     = (r_state == c_WAIT);
  assign w_cfg_err   = ({1'b0, cfg_num_channel} > c_PTAB_LIMIT);
  assign w_ch_next   = r_channel + 1'b1;
  // External abort outranks a same-cycle end_flag; timeout only fires while end_flag is low.
  assign w_abort     = (cfg_abort && (r_state != c_IDLE)) ||
                       ((r_state == c_WAIT) && !eng_end_flag && w_wd_expire);
  assign cur_channel = eng_channel_idx;

  requant_seq_watchdog #(
    .BW_TIMEOUT (BW_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rstnn  (rstnn),
    .clear  (w_wd_clear),
    .enable (w_wd_en),
    .limit  (r_timeout),
    .expire (w_wd_expire)
  );

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_state         <= c_IDLE;
      r_channel       <= '0;
      r_num_ch        <= '0;
      r_timeout       <= '0;
      ptab_renable    <= 1'b0;
      ptab_rindex     <= '0;
      eng_start       <= 1'b0;
      eng_channel_idx <= '0;
      eng_m0          <= '0;
      eng_shift       <= '0;
      eng_bias        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      aborted         <= 1'b0;
      err_cfg         <= 1'b0;
      irq             <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (w_abort) begin
        eng_start    <= 1'b0;
        ptab_renable <= 1'b0;
        aborted      <= 1'b1;
        irq          <= 1'b1;
        busy         <= 1'b0;
        r_state      <= c_IDLE;
      end else begin
        case (r_state)
          c_IDLE: begin
            if (cfg_start) begin
              r_num_ch  <= cfg_num_channel;
              r_timeout <= cfg_timeout;
              r_channel <= '0;
              done      <= 1'b0;
              aborted   <= 1'b0;
              err_cfg   <= 1'b0;
              if (w_cfg_err) begin
                err_cfg <= 1'b1;
                irq     <= 1'b1;
              end else if (cfg_num_channel == '0) begin
                busy    <= 1'b1;
                r_state <= c_DONE;
              end else begin
                busy         <= 1'b1;
                ptab_renable <= 1'b1;
                ptab_rindex  <= '0;
                r_state      <= c_FETCH;
              end
            end
          end
          c_FETCH: begin
            ptab_renable <= 1'b0;
            r_state      <= c_LATCH;
          end
          c_LATCH: begin
            eng_m0          <= ptab_rdata_m0;
            eng_shift       <= ptab_rdata_shift;
            eng_bias        <= ptab_rdata_bias;
            eng_channel_idx <= r_channel;
            r_state         <= c_LAUNCH;
          end
          c_LAUNCH: begin
            // A stale end_flag from the previous run must clear before we start again.
            if (!eng_end_flag) begin
              eng_start <= 1'b1;
              r_state   <= c_WAIT;
            end
          end
          c_WAIT: begin
            if (eng_end_flag) begin
              eng_start <= 1'b0;
              r_state   <= c_DRAIN;
            end
          end
          c_DRAIN: begin
            if (!eng_end_flag) r_state <= c_NEXT;
          end
          c_NEXT: begin
            r_channel <= w_ch_next;
            if (w_ch_next == r_num_ch) begin
              r_state <= c_DONE;
            end else begin
              ptab_renable <= 1'b1;
              ptab_rindex  <= w_ch_next[BW_PINDEX-1:0];
              r_state      <= c_FETCH;
            end
          end
          c_DONE: begin
            done    <= 1'b1;
            irq     <= 1'b1;
            busy    <= 1'b0;
            r_state <= c_IDLE;
          end
          default: r_state <= c_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_requant_channel_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_requant_channel_sequencer : directed/random checks of the     |
// |                                channel sequencer.   Rev 1.0      |
// +------------------------------------------------------------------+
module tb_requant_channel_sequencer;

  localparam int BW_DATA    = 32;
  localparam int BW_CH      = 16;
  localparam int PTAB_DEPTH = 256;
  localparam int BW_PINDEX  = 8;
  localparam int BW_TIMEOUT = 32;

  logic                  clk = 1'b0;
  logic                  rstnn = 1'b0;
  logic                  cfg_start = 1'b0;
  logic                  cfg_abort = 1'b0;
  logic [BW_CH-1:0]      cfg_num_channel = '0;
  logic [BW_TIMEOUT-1:0] cfg_timeout = '0;
  logic                  ptab_renable;
  logic [BW_PINDEX-1:0]  ptab_rindex;
  logic [BW_DATA-1:0]    rd_m0 = '0, rd_sh = '0, rd_bi = '0;
  logic                  eng_start;
  logic [BW_CH-1:0]      eng_channel_idx;
  logic [BW_DATA-1:0]    eng_m0, eng_shift, eng_bias;
  logic                  eng_end_flag;
  logic                  busy, done, aborted, err_cfg, irq;
  logic [BW_CH-1:0]      cur_channel;

  always #5 clk = ~clk;

  requant_channel_sequencer #(
    .BW_DATA(BW_DATA), .BW_CH(BW_CH), .PTAB_DEPTH(PTAB_DEPTH),
    .BW_PINDEX(BW_PINDEX), .BW_TIMEOUT(BW_TIMEOUT)
  ) dut (
    .clk(clk), .rstnn(rstnn), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_num_channel(cfg_num_channel), .cfg_timeout(cfg_timeout),
    .ptab_renable(ptab_renable), .ptab_rindex(ptab_rindex),
    .ptab_rdata_m0(rd_m0), .ptab_rdata_shift(rd_sh), .ptab_rdata_bias(rd_bi),
    .eng_start(eng_start), .eng_channel_idx(eng_channel_idx),
    .eng_m0(eng_m0), .eng_shift(eng_shift), .eng_bias(eng_bias),
    .eng_end_flag(eng_end_flag), .busy(busy), .done(done), .aborted(aborted),
    .err_cfg(err_cfg), .irq(irq), .cur_channel(cur_channel)
  );

  // Parameter table: synchronous read, data one cycle after renable.
  logic [BW_DATA-1:0] tab_m0 [PTAB_DEPTH];
  logic [BW_DATA-1:0] tab_sh [PTAB_DEPTH];
  logic [BW_DATA-1:0] tab_bi [PTAB_DEPTH];

  always @(posedge clk) begin
    if (ptab_renable) begin
      rd_m0 <= tab_m0[ptab_rindex];
      rd_sh <= tab_sh[ptab_rindex];
      rd_bi <= tab_bi[ptab_rindex];
    end
  end

  // Engine model: end_flag rises `delay` cycles into start, falls 2 cycles after start drops.
  logic        model_end;
  logic        stale_end = 1'b0;
  logic        hang_en = 1'b0;
  logic [15:0] hang_ch = '0;
  int unsigned delay = 10;
  int unsigned sc, fc;

  assign eng_end_flag = model_end | stale_end;

  always @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      model_end <= 1'b0;
      sc        <= 0;
      fc        <= 0;
    end else if (eng_start) begin
      fc <= 0;
      if (!(hang_en && eng_channel_idx == hang_ch)) begin
        sc <= sc + 1;
        if (sc + 1 >= delay) model_end <= 1'b1;
      end
    end else begin
      sc <= 0;
      if (model_end) begin
        fc <= fc + 1;
        if (fc + 1 >= 2) begin
          model_end <= 1'b0;
          fc        <= 0;
        end
      end
    end
  end

  // Activity monitor, sampled on the falling edge.
  int   irq_cnt = 0, ren_cnt = 0, start_cnt = 0, stab_viol = 0, cur_len = 0, last_len = 0;
  logic prev_start = 1'b0;
  logic [31:0] log_ch [64];
  logic [31:0] log_m0 [64];
  logic [31:0] log_sh [64];
  logic [31:0] log_bi [64];

  always @(negedge clk) begin
    if (irq) irq_cnt <= irq_cnt + 1;
    if (ptab_renable) ren_cnt <= ren_cnt + 1;
    if (eng_start && !prev_start) begin
      log_ch[start_cnt % 64] <= 32'(eng_channel_idx);
      log_m0[start_cnt % 64] <= eng_m0;
      log_sh[start_cnt % 64] <= eng_shift;
      log_bi[start_cnt % 64] <= eng_bias;
      start_cnt <= start_cnt + 1;
      cur_len   <= 1;
    end else if (eng_start) begin
      cur_len <= cur_len + 1;
      if (eng_m0 != log_m0[(start_cnt-1) % 64] || eng_shift != log_sh[(start_cnt-1) % 64] ||
          eng_bias != log_bi[(start_cnt-1) % 64] || 32'(eng_channel_idx) != log_ch[(start_cnt-1) % 64])
        stab_viol <= stab_viol + 1;
    end
    if (!eng_start && prev_start) last_len <= cur_len;
    prev_start <= eng_start;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int n, input int t);
    cfg_num_channel = 16'(n);
    cfg_timeout     = 32'(t);
    cfg_start       = 1'b1;
    tick(1);
    cfg_start       = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  // Reference: channel i must be launched with table entry i.
  task automatic check_run(input string tag, input int s0, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_ch%0d_idx", tag, i), 64'(log_ch[(s0+i) % 64]), 64'(i));
      check($sformatf("%s_ch%0d_m0", tag, i), 64'(log_m0[(s0+i) % 64]), 64'(tab_m0[i]));
      check($sformatf("%s_ch%0d_sh", tag, i), 64'(log_sh[(s0+i) % 64]), 64'(tab_sh[i]));
      check($sformatf("%s_ch%0d_bi", tag, i), 64'(log_bi[(s0+i) % 64]), 64'(tab_bi[i]));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int s0, i0, r0, n, k;
    for (int i = 0; i < PTAB_DEPTH; i++) begin
      tab_m0[i] = $urandom();
      tab_sh[i] = $urandom();
      tab_bi[i] = $urandom();
    end

    // Reset values
    rstnn = 1'b0;
    tick(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_aborted", 64'(aborted), 64'd0);
    check("rst_err_cfg", 64'(err_cfg), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_eng_start", 64'(eng_start), 64'd0);
    check("rst_renable", 64'(ptab_renable), 64'd0);
    check("rst_cur_channel", 64'(cur_channel), 64'd0);
    check("rst_eng_m0", 64'(eng_m0), 64'd0);
    rstnn = 1'b1;
    tick(2);

    // Abort while idle has no effect
    cfg_abort = 1'b1;
    tick(1);
    cfg_abort = 1'b0;
    tick(2);
    check("idle_abort_aborted", 64'(aborted), 64'd0);
    check("idle_abort_irq", 64'(irq_cnt), 64'd0);

    // Normal runs: the first with 3 channels, the second random
    for (int r = 0; r < 2; r++) begin
      n     = (r == 0) ? 3 : int'($urandom_range(4, 8));
      delay = (r == 0) ? 10 : $urandom_range(1, 12);
      s0 = start_cnt; i0 = irq_cnt; r0 = ren_cnt;
      pulse_start(n, 0);
      check("run_busy_high", 64'(busy), 64'd1);
      wait_idle("run_busy_low", 3000);
      tick(2);
      check("run_done", 64'(done), 64'd1);
      check("run_aborted", 64'(aborted), 64'd0);
      check("run_irq_once", 64'(irq_cnt - i0), 64'd1);
      check("run_starts", 64'(start_cnt - s0), 64'(n));
      check("run_fetches", 64'(ren_cnt - r0), 64'(n));
      check("run_stable", 64'(stab_viol), 64'd0);
      check_run("run", s0, n);
    end

    // Zero channels completes immediately
    s0 = start_cnt; i0 = irq_cnt; r0 = ren_cnt;
    pulse_start(0, 0);
    tick(1);
    check("zero_done", 64'(done), 64'd1);
    tick(2);
    check("zero_busy", 64'(busy), 64'd0);
    check("zero_irq", 64'(irq_cnt - i0), 64'd1);
    check("zero_starts", 64'(start_cnt - s0), 64'd0);
    check("zero_fetches", 64'(ren_cnt - r0), 64'd0);

    // Oversized channel count
    s0 = start_cnt; i0 = irq_cnt; r0 = ren_cnt;
    pulse_start(PTAB_DEPTH + 1, 0);
    check("cfgerr_flag", 64'(err_cfg), 64'd1);
    check("cfgerr_busy", 64'(busy), 64'd0);
    check("cfgerr_done_cleared", 64'(done), 64'd0);
    tick(3);
    check("cfgerr_irq", 64'(irq_cnt - i0), 64'd1);
    check("cfgerr_starts", 64'(start_cnt - s0), 64'd0);
    check("cfgerr_fetches", 64'(ren_cnt - r0), 64'd0);
    delay = 3;
    pulse_start(1, 0);
    check("cfgerr_cleared", 64'(err_cfg), 64'd0);
    wait_idle("cfgerr_recover_busy", 500);
    tick(2);
    check("cfgerr_recover_done", 64'(done), 64'd1);

    // Watchdog timeout on channel 1
    hang_en = 1'b1; hang_ch = 16'd1; delay = 5;
    s0 = start_cnt; i0 = irq_cnt;
    pulse_start(3, 50);
    wait_idle("tmo_busy", 1000);
    tick(2);
    check("tmo_aborted", 64'(aborted), 64'd1);
    check("tmo_done", 64'(done), 64'd0);
    check("tmo_cur_channel", 64'(cur_channel), 64'd1);
    check("tmo_eng_start", 64'(eng_start), 64'd0);
    check("tmo_start_len", 64'(last_len), 64'd50);
    check("tmo_starts", 64'(start_cnt - s0), 64'd2);
    check("tmo_irq", 64'(irq_cnt - i0), 64'd1);
    hang_en = 1'b0;

    // Abort during channel 2 of 5; a second start while busy is ignored
    delay = 30;
    s0 = start_cnt; i0 = irq_cnt;
    pulse_start(5, 0);
    tick(3);
    pulse_start(1, 0);
    k = 0;
    while (!(eng_start && eng_channel_idx == 16'd2) && k < 1000) begin
      tick(1);
      k++;
    end
    check("abort_reach_ch2", 64'(k < 1000), 64'd1);
    tick(3);
    cfg_abort = 1'b1;
    tick(1);
    cfg_abort = 1'b0;
    check("abort_eng_start", 64'(eng_start), 64'd0);
    check("abort_aborted", 64'(aborted), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_irq", 64'(irq), 64'd1);
    check("abort_cur_channel", 64'(cur_channel), 64'd2);
    tick(2);
    check("abort_starts", 64'(start_cnt - s0), 64'd3);
    check("abort_irq_once", 64'(irq_cnt - i0), 64'd1);

    // Stale end_flag holds the sequencer in LAUNCH
    stale_end = 1'b1; delay = 4;
    s0 = start_cnt; r0 = ren_cnt;
    pulse_start(2, 0);
    tick(12);
    check("stale_hold_start", 64'(eng_start), 64'd0);
    check("stale_hold_busy", 64'(busy), 64'd1);
    check("stale_hold_starts", 64'(start_cnt - s0), 64'd0);
    check("stale_hold_fetches", 64'(ren_cnt - r0), 64'd1);
    stale_end = 1'b0;
    wait_idle("stale_busy", 500);
    tick(2);
    check("stale_done", 64'(done), 64'd1);
    check("stale_starts", 64'(start_cnt - s0), 64'd2);
    check_run("stale", s0, 2);

    // Asynchronous reset in the middle of WAIT
    delay = 40;
    pulse_start(3, 0);
    k = 0;
    while (!(eng_start && eng_channel_idx == 16'd1) && k < 500) begin
      tick(1);
      k++;
    end
    check("rstmid_reach_ch1", 64'(k < 500), 64'd1);
    tick(2);
    i0 = irq_cnt;
    rstnn = 1'b0;
    #1;
    check("rstmid_eng_start", 64'(eng_start), 64'd0);
    check("rstmid_busy", 64'(busy), 64'd0);
    check("rstmid_cur_channel", 64'(cur_channel), 64'd0);
    check("rstmid_eng_m0", 64'(eng_m0), 64'd0);
    check("rstmid_irq", 64'(irq), 64'd0);
    tick(3);
    check("rstmid_no_irq", 64'(irq_cnt - i0), 64'd0);
    rstnn = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
